// File: rtl/fox_packet_pkg.sv
// Shared field-width defaults and packet sizing for the Fox TX buffer, router and RX unpacker.
package fox_packet_pkg;

  localparam int DEF_COORD_BITS           = 1;
  localparam int DEF_MULTICAST_GROUP_BITS = 1;
  localparam int DEF_MATRIX_TYPE_BITS     = 1;
  localparam int DEF_MATRIX_COORD_BITS    = 8;
  localparam int DEF_MATRIX_ELEMENT_BITS  = 32;
  localparam int DEF_FIFO_DEPTH           = 4;

  // Two coordinates, group, done+result flags, type, two matrix coords, element.
  function automatic int packet_bits(input int coordBits, input int groupBits,
                                     input int typeBits, input int matrixCoordBits,
                                     input int elementBits);
    return 2 * coordBits + groupBits + 2 + typeBits + 2 * matrixCoordBits + elementBits;
  endfunction

endpackage

// File: rtl/fox_sync_fifo.sv
// First-word-fall-through FIFO; the head entry is always visible on data_o while not empty.
module fox_sync_fifo
  import fox_packet_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pushOk;
  logic             popOk;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign popOk  = pop_i && !empty_o;
  assign pushOk = push_i && (!full_o || popOk);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (popOk)  rdPtr_d = rdPtr_q + PTR_W'(1);
    unique case ({pushOk, popOk})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/fox_packet_tx_buffer.sv
// Stages processor field writes, commits packed words into a FWFT FIFO and drains it to the router.
module fox_packet_tx_buffer
  import fox_packet_pkg::*;
#(
  parameter int COORD_BITS           = DEF_COORD_BITS,
  parameter int MULTICAST_GROUP_BITS = DEF_MULTICAST_GROUP_BITS,
  parameter int MATRIX_TYPE_BITS     = DEF_MATRIX_TYPE_BITS,
  parameter int MATRIX_COORD_BITS    = DEF_MATRIX_COORD_BITS,
  parameter int MATRIX_ELEMENT_BITS  = DEF_MATRIX_ELEMENT_BITS,
  parameter int FIFO_DEPTH           = DEF_FIFO_DEPTH,
  localparam int PACKET_BITS = packet_bits(COORD_BITS, MULTICAST_GROUP_BITS, MATRIX_TYPE_BITS,
                                           MATRIX_COORD_BITS, MATRIX_ELEMENT_BITS)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [COORD_BITS-1:0]           x_coord_in,
  input  logic                            x_coord_in_valid,
  input  logic [COORD_BITS-1:0]           y_coord_in,
  input  logic                            y_coord_in_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
  input  logic                            multicast_group_in_valid,
  input  logic                            done_flag_in,
  input  logic                            done_flag_in_valid,
  input  logic                            result_flag_in,
  input  logic                            result_flag_in_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
  input  logic                            matrix_type_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
  input  logic                            matrix_x_coord_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
  input  logic                            matrix_y_coord_in_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
  input  logic                            matrix_element_in_valid,
  input  logic                            packet_complete_in,
  output logic                            message_out_ready,
  output logic [PACKET_BITS-1:0]          packet_out,
  output logic                            packet_out_valid,
  input  logic                            packet_out_ready,
  output logic                            overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [COORD_BITS-1:0]           xCoord_q, xCoord_d;
  logic [COORD_BITS-1:0]           yCoord_q, yCoord_d;
  logic [MULTICAST_GROUP_BITS-1:0] group_q, group_d;
  logic                            done_q, done_d;
  logic                            result_q, result_d;
  logic [MATRIX_TYPE_BITS-1:0]     mType_q, mType_d;
  logic [MATRIX_COORD_BITS-1:0]    mX_q, mX_d;
  logic [MATRIX_COORD_BITS-1:0]    mY_q, mY_d;
  logic [MATRIX_ELEMENT_BITS-1:0]  elem_q, elem_d;
  logic                            overflow_q, overflow_d;

  logic [PACKET_BITS-1:0] packedWord;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [CNT_W-1:0]       fifoCount;
  logic                   pop;
  logic                   accept;
  logic                   push;

  // The next-state values double as the bypass path, so a write landing with the
  // commit strobe is already part of the committed word.
  always_comb begin
    xCoord_d = x_coord_in_valid        ? x_coord_in         : xCoord_q;
    yCoord_d = y_coord_in_valid        ? y_coord_in         : yCoord_q;
    group_d  = multicast_group_in_valid ? multicast_group_in : group_q;
    done_d   = done_flag_in_valid      ? done_flag_in       : done_q;
    result_d = result_flag_in_valid    ? result_flag_in     : result_q;
    mType_d  = matrix_type_in_valid    ? matrix_type_in     : mType_q;
    mX_d     = matrix_x_coord_in_valid ? matrix_x_coord_in  : mX_q;
    mY_d     = matrix_y_coord_in_valid ? matrix_y_coord_in  : mY_q;
    elem_d   = matrix_element_in_valid ? matrix_element_in  : elem_q;
  end

  assign packedWord = {yCoord_d, xCoord_d, group_d, done_d, result_d,
                       mType_d, mY_d, mX_d, elem_d};

  assign pop        = packet_out_valid && packet_out_ready;
  assign accept     = !fifoFull || pop;
  assign push       = packet_complete_in && accept;
  assign overflow_d = overflow_q || (packet_complete_in && !accept);

  assign packet_out_valid  = !fifoEmpty;
  assign message_out_ready = (fifoCount < CNT_W'(FIFO_DEPTH));
  assign overflow          = overflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xCoord_q   <= '0;
      yCoord_q   <= '0;
      group_q    <= '0;
      done_q     <= 1'b0;
      result_q   <= 1'b0;
      mType_q    <= '0;
      mX_q       <= '0;
      mY_q       <= '0;
      elem_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      xCoord_q   <= xCoord_d;
      yCoord_q   <= yCoord_d;
      group_q    <= group_d;
      done_q     <= done_d;
      result_q   <= result_d;
      mType_q    <= mType_d;
      mX_q       <= mX_d;
      mY_q       <= mY_d;
      elem_q     <= elem_d;
      overflow_q <= overflow_d;
    end
  end

  fox_sync_fifo #(
    .WIDTH (PACKET_BITS),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (packedWord),
    .pop_i   (pop),
    .data_o  (packet_out),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

endmodule

// File: tb/tb_fox_packet_tx_buffer.sv
// Self-checking bench for fox_packet_tx_buffer: directed vectors plus a queue-based random scoreboard.
module tb_fox_packet_tx_buffer;
  import fox_packet_pkg::*;

  localparam int PB    = packet_bits(1, 1, 1, 8, 32);
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset_n;
  logic          x_coord_in, x_coord_in_valid;
  logic          y_coord_in, y_coord_in_valid;
  logic          multicast_group_in, multicast_group_in_valid;
  logic          done_flag_in, done_flag_in_valid;
  logic          result_flag_in, result_flag_in_valid;
  logic          matrix_type_in, matrix_type_in_valid;
  logic [7:0]    matrix_x_coord_in;
  logic          matrix_x_coord_in_valid;
  logic [7:0]    matrix_y_coord_in;
  logic          matrix_y_coord_in_valid;
  logic [31:0]   matrix_element_in;
  logic          matrix_element_in_valid;
  logic          packet_complete_in;
  logic          message_out_ready;
  logic [PB-1:0] packet_out;
  logic          packet_out_valid;
  logic          packet_out_ready;
  logic          overflow;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        elemV;
    logic [31:0] elem;
    logic        cmp;
    logic        rdy;
    logic        expValid;
    logic        expMRdy;
    logic        expOvf;
    logic [31:0] expElem;
  } vec_t;

  vec_t vecs[9];

  // Reference model state: staged fields, queued packets and the sticky drop flag.
  logic          sY, sX, sG, sD, sR, sT;
  logic [7:0]    sMy, sMx;
  logic [31:0]   sE;
  logic [PB-1:0] modelQ[$];
  logic          modelOvf;

  fox_packet_tx_buffer dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .x_coord_in               (x_coord_in),
    .x_coord_in_valid         (x_coord_in_valid),
    .y_coord_in               (y_coord_in),
    .y_coord_in_valid         (y_coord_in_valid),
    .multicast_group_in       (multicast_group_in),
    .multicast_group_in_valid (multicast_group_in_valid),
    .done_flag_in             (done_flag_in),
    .done_flag_in_valid       (done_flag_in_valid),
    .result_flag_in           (result_flag_in),
    .result_flag_in_valid     (result_flag_in_valid),
    .matrix_type_in           (matrix_type_in),
    .matrix_type_in_valid     (matrix_type_in_valid),
    .matrix_x_coord_in        (matrix_x_coord_in),
    .matrix_x_coord_in_valid  (matrix_x_coord_in_valid),
    .matrix_y_coord_in        (matrix_y_coord_in),
    .matrix_y_coord_in_valid  (matrix_y_coord_in_valid),
    .matrix_element_in        (matrix_element_in),
    .matrix_element_in_valid  (matrix_element_in_valid),
    .packet_complete_in       (packet_complete_in),
    .message_out_ready        (message_out_ready),
    .packet_out               (packet_out),
    .packet_out_valid         (packet_out_valid),
    .packet_out_ready         (packet_out_ready),
    .overflow                 (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [PB-1:0] packWord(input logic y, input logic x, input logic g,
                                             input logic d, input logic r, input logic t,
                                             input logic [7:0] my, input logic [7:0] mx,
                                             input logic [31:0] e);
    return {y, x, g, d, r, t, my, mx, e};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else passes++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clearInputs();
    x_coord_in_valid = 0; y_coord_in_valid = 0; multicast_group_in_valid = 0;
    done_flag_in_valid = 0; result_flag_in_valid = 0; matrix_type_in_valid = 0;
    matrix_x_coord_in_valid = 0; matrix_y_coord_in_valid = 0; matrix_element_in_valid = 0;
    packet_complete_in = 0;
  endtask

  task automatic doReset();
    reset_n = 0;
    clearInputs();
    packet_out_ready = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic applyStimulus(input logic elemV, input logic [31:0] elem,
                               input logic cmp, input logic rdy);
    clearInputs();
    matrix_element_in_valid = elemV;
    matrix_element_in       = elem;
    packet_complete_in      = cmp;
    packet_out_ready        = rdy;
    tick();
    clearInputs();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    logic [PB-1:0] word;
    logic          pop, acc;
    sY  = y_coord_in_valid        ? y_coord_in         : sY;
    sX  = x_coord_in_valid        ? x_coord_in         : sX;
    sG  = multicast_group_in_valid ? multicast_group_in : sG;
    sD  = done_flag_in_valid      ? done_flag_in       : sD;
    sR  = result_flag_in_valid    ? result_flag_in     : sR;
    sT  = matrix_type_in_valid    ? matrix_type_in     : sT;
    sMy = matrix_y_coord_in_valid ? matrix_y_coord_in  : sMy;
    sMx = matrix_x_coord_in_valid ? matrix_x_coord_in  : sMx;
    sE  = matrix_element_in_valid ? matrix_element_in  : sE;
    word = packWord(sY, sX, sG, sD, sR, sT, sMy, sMx, sE);
    pop  = (modelQ.size() > 0) && packet_out_ready;
    acc  = packet_complete_in && ((modelQ.size() < DEPTH) || pop);
    if (pop) void'(modelQ.pop_front());
    if (acc) modelQ.push_back(word);
    if (packet_complete_in && !acc) modelOvf = 1;
  endtask

  initial begin
    logic [PB-1:0] expWord;
    int            bias;

    reset_n = 0;
    x_coord_in = 0; y_coord_in = 0; multicast_group_in = 0; done_flag_in = 0;
    result_flag_in = 0; matrix_type_in = 0; matrix_x_coord_in = 0;
    matrix_y_coord_in = 0; matrix_element_in = 0;
    clearInputs();
    packet_out_ready = 0;

    vecs[0] = '{1, 32'd1, 1, 0, 1, 1, 0, 32'd1};
    vecs[1] = '{1, 32'd2, 1, 0, 1, 1, 0, 32'd1};
    vecs[2] = '{1, 32'd3, 1, 0, 1, 1, 0, 32'd1};
    vecs[3] = '{1, 32'd4, 1, 0, 1, 0, 0, 32'd1};
    vecs[4] = '{1, 32'd5, 1, 0, 1, 0, 1, 32'd1};
    vecs[5] = '{0, 32'd0, 0, 1, 1, 1, 1, 32'd2};
    vecs[6] = '{0, 32'd0, 0, 1, 1, 1, 1, 32'd3};
    vecs[7] = '{0, 32'd0, 0, 1, 1, 1, 1, 32'd4};
    vecs[8] = '{0, 32'd0, 0, 1, 0, 1, 1, 32'd0};

    // Reset state and single-packet packing / latency.
    doReset();
    checkOutput("reset_valid", 64'(packet_out_valid), 64'd0);
    checkOutput("reset_packet", 64'(packet_out), 64'd0);
    checkOutput("reset_mready", 64'(message_out_ready), 64'd1);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);

    x_coord_in = 1; x_coord_in_valid = 1;
    y_coord_in = 0; y_coord_in_valid = 1;
    multicast_group_in = 1; multicast_group_in_valid = 1;
    matrix_type_in = 1; matrix_type_in_valid = 1;
    matrix_x_coord_in = 8'd3; matrix_x_coord_in_valid = 1;
    matrix_y_coord_in = 8'd5; matrix_y_coord_in_valid = 1;
    matrix_element_in = 32'hDEADBEEF; matrix_element_in_valid = 1;
    tick();
    clearInputs();
    checkOutput("staged_no_commit_valid", 64'(packet_out_valid), 64'd0);
    packet_complete_in = 1;
    tick();
    clearInputs();
    expWord = packWord(0, 1, 1, 0, 0, 1, 8'd5, 8'd3, 32'hDEADBEEF);
    checkOutput("t1_valid", 64'(packet_out_valid), 64'd1);
    checkOutput("t1_packet", 64'(packet_out), 64'(expWord));
    packet_out_ready = 1;
    tick();
    packet_out_ready = 0;
    checkOutput("t1_valid_drop", 64'(packet_out_valid), 64'd0);

    // Fill to full with stall, drop one, then drain in order.
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].elemV, vecs[i].elem, vecs[i].cmp, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_valid", i), 64'(packet_out_valid), 64'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_mready", i), 64'(message_out_ready), 64'(vecs[i].expMRdy));
      checkOutput($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].expOvf));
      if (vecs[i].expValid)
        checkOutput($sformatf("vec%0d_elem", i), 64'(packet_out[31:0]), 64'(vecs[i].expElem));
    end
    packet_out_ready = 0;

    // Commit into a full FIFO while the head is popped in the same cycle.
    doReset();
    for (int k = 10; k < 14; k++) applyStimulus(1, 32'(k), 1, 0);
    checkOutput("t3_full_mready", 64'(message_out_ready), 64'd0);
    applyStimulus(1, 32'd14, 1, 1);
    checkOutput("t3_pushpop_mready", 64'(message_out_ready), 64'd0);
    checkOutput("t3_pushpop_overflow", 64'(overflow), 64'd0);
    for (int k = 11; k < 15; k++) begin
      checkOutput($sformatf("t3_order%0d_valid", k), 64'(packet_out_valid), 64'd1);
      checkOutput($sformatf("t3_order%0d_elem", k), 64'(packet_out[31:0]), 64'(k));
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("t3_drained_valid", 64'(packet_out_valid), 64'd0);
    checkOutput("t3_end_overflow", 64'(overflow), 64'd0);
    packet_out_ready = 0;

    // Field writes coinciding with the commit strobe are bypassed; unwritten fields repeat.
    doReset();
    matrix_element_in = 32'h55; matrix_element_in_valid = 1;
    matrix_x_coord_in = 8'd7; matrix_x_coord_in_valid = 1;
    packet_complete_in = 1;
    tick();
    clearInputs();
    expWord = packWord(0, 0, 0, 0, 0, 0, 8'd0, 8'd7, 32'h55);
    checkOutput("t4_bypass_packet", 64'(packet_out), 64'(expWord));
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    packet_out_ready = 0;
    checkOutput("t4_repeat_valid", 64'(packet_out_valid), 64'd1);
    checkOutput("t4_repeat_packet", 64'(packet_out), 64'(expWord));

    // Asynchronous reset with three packets queued and overflow set.
    doReset();
    for (int k = 1; k < 6; k++) applyStimulus(1, 32'(k), 1, 0);
    applyStimulus(0, 0, 0, 1);
    packet_out_ready = 0;
    checkOutput("t5_pre_overflow", 64'(overflow), 64'd1);
    checkOutput("t5_pre_valid", 64'(packet_out_valid), 64'd1);
    #2;
    reset_n = 0;
    #1;
    checkOutput("t5_async_valid", 64'(packet_out_valid), 64'd0);
    checkOutput("t5_async_overflow", 64'(overflow), 64'd0);
    checkOutput("t5_async_mready", 64'(message_out_ready), 64'd1);
    @(negedge clk);
    reset_n = 1;
    packet_out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("t5_no_stale%0d", k), 64'(packet_out_valid), 64'd0);
    end
    packet_out_ready = 0;

    // Random field writes, commits and back-pressure against the queue model.
    doReset();
    {sY, sX, sG, sD, sR, sT} = '0;
    sMy = 0; sMx = 0; sE = 0;
    modelQ.delete();
    modelOvf = 0;
    for (int i = 0; i < 10000; i++) begin
      bias = (i < 5000) ? 8 : (((i / 250) % 2) == 1 ? 2 : 9);
      x_coord_in = 1'($urandom);           x_coord_in_valid = ($urandom_range(3, 0) == 0);
      y_coord_in = 1'($urandom);           y_coord_in_valid = ($urandom_range(3, 0) == 0);
      multicast_group_in = 1'($urandom);   multicast_group_in_valid = ($urandom_range(3, 0) == 0);
      done_flag_in = 1'($urandom);         done_flag_in_valid = ($urandom_range(3, 0) == 0);
      result_flag_in = 1'($urandom);       result_flag_in_valid = ($urandom_range(3, 0) == 0);
      matrix_type_in = 1'($urandom);       matrix_type_in_valid = ($urandom_range(3, 0) == 0);
      matrix_x_coord_in = 8'($urandom);    matrix_x_coord_in_valid = ($urandom_range(3, 0) == 0);
      matrix_y_coord_in = 8'($urandom);    matrix_y_coord_in_valid = ($urandom_range(3, 0) == 0);
      matrix_element_in = $urandom;        matrix_element_in_valid = ($urandom_range(3, 0) == 0);
      packet_complete_in = ($urandom_range(2, 0) == 0);
      packet_out_ready   = ($urandom_range(9, 0) < bias);
      modelStep();
      tick();
      checkOutput("rnd_valid", 64'(packet_out_valid), 64'(modelQ.size() > 0));
      checkOutput("rnd_mready", 64'(message_out_ready), 64'(modelQ.size() < DEPTH));
      checkOutput("rnd_overflow", 64'(overflow), 64'(modelOvf));
      if (modelQ.size() > 0) checkOutput("rnd_packet", 64'(packet_out), 64'(modelQ[0]));
    end
    clearInputs();
    packet_out_ready = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
